// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA pattern client.
//   - MODE_* : pattern-mode encodings held in the frame-latched mode register
//   - expand3 : turns a 3-bit R/G/B selector into three full-scale channels
//   - grey_level : mid-grey channel value for a given channel width
// Channels are returned in MAX_CW-bit lanes so that callers of any colour
// width can pick their slice with a cast.
package vga_pkg;

    localparam logic [1:0] MODE_BORDER  = 2'b00;
    localparam logic [1:0] MODE_PRODUCT = 2'b01;
    localparam logic [1:0] MODE_BARS    = 2'b10;
    localparam logic [1:0] MODE_OVERLAY = 2'b11;

    localparam int unsigned MAX_CW = 16;

    // Lane layout: [3*MAX_CW-1:2*MAX_CW]=R, [2*MAX_CW-1:MAX_CW]=G, [MAX_CW-1:0]=B.
    function automatic logic [3*MAX_CW-1:0] expand3(input logic [2:0] sel,
                                                    input int unsigned cw);
        logic [MAX_CW-1:0] full;
        full    = MAX_CW'((32'd1 << cw) - 32'd1);
        expand3 = {(sel[2] ? full : {MAX_CW{1'b0}}),
                   (sel[1] ? full : {MAX_CW{1'b0}}),
                   (sel[0] ? full : {MAX_CW{1'b0}})};
    endfunction

    // Grey constant: 2^(cw-1)-1 per channel.
    function automatic logic [MAX_CW-1:0] grey_level(input int unsigned cw);
        grey_level = MAX_CW'((32'd1 << (cw - 32'd1)) - 32'd1);
    endfunction

endpackage

// File: rtl/vga_frame_ticker.sv
// vga_frame_ticker: frame-rate scroll counter.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   vblank_i      : vertical blanking from the timing generator
//   scroll_o      : scroll offset, +1 every FRAME_DIV frames, wraps mod 2^COORD_W
// The VBlank delay register resets to 1 so a VBlank already high when reset
// releases is not mistaken for a rising edge.
module vga_frame_ticker #(
    parameter int COORD_W   = 11,
    parameter int FRAME_DIV = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               vblank_i,
    output logic [COORD_W-1:0] scroll_o
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    logic               vblank_d_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] scroll_q, scroll_d;
    logic               tick_s;

    // Frame tick detection, divider and scroll next-state.
    always_comb begin
        tick_s   = vblank_i & ~vblank_d_q;
        div_d    = div_q;
        scroll_d = scroll_q;
        if (tick_s) begin
            if (div_q == DIV_LAST) begin
                div_d    = {DIV_W{1'b0}};
                scroll_d = scroll_q + COORD_W'(1);
            end else begin
                div_d    = div_q + DIV_W'(1);
            end
        end else begin
            div_d    = div_q;
        end
    end

    // Ticker state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vblank_d_q <= 1'b1;
            div_q      <= {DIV_W{1'b0}};
            scroll_q   <= {COORD_W{1'b0}};
        end else begin
            vblank_d_q <= vblank_i;
            div_q      <= div_d;
            scroll_q   <= scroll_d;
        end
    end

    assign scroll_o = scroll_q;

endmodule

// File: rtl/vga_pattern_client.sv
// vga_pattern_client: pipelined VGA pattern generator.
//   CLK_100MHz, RST_N         : pixel clock, asynchronous active-low reset
//   CurrentX/CurrentY         : pixel coordinates from the timing generator
//   VBlank/HBlank             : blanking flags
//   SWITCH                    : [2:0] colour select, [4:3] mode (latched in VBlank)
//   OVL_RED/GREEN/BLUE/VALID  : overlay pixel
//   RED/GREEN/BLUE            : registered colour, 2 clocks after the inputs
//   SCROLL                    : current scroll offset
// Build option VGA_SCROLL_EN: when defined the frame ticker drives SCROLL and
// the scrolled X; when undefined SCROLL is 0 and X is used unscrolled.
module vga_pattern_client
    import vga_pkg::*;
#(
    parameter int COLOR_W   = 4,
    parameter int COORD_W   = 11,
    parameter int H_ACTIVE  = 800,
    parameter int V_ACTIVE  = 600,
    parameter int BORDER    = 100,
    parameter int BAR_SHIFT = 5,
    parameter int FRAME_DIV = 4
) (
    input  logic               CLK_100MHz,
    input  logic               RST_N,
    input  logic [COORD_W-1:0] CurrentX,
    input  logic [COORD_W-1:0] CurrentY,
    input  logic               VBlank,
    input  logic               HBlank,
    input  logic [4:0]         SWITCH,
    input  logic [COLOR_W-1:0] OVL_RED,
    input  logic [COLOR_W-1:0] OVL_GREEN,
    input  logic [COLOR_W-1:0] OVL_BLUE,
    input  logic               OVL_VALID,
    output logic [COLOR_W-1:0] RED,
    output logic [COLOR_W-1:0] GREEN,
    output logic [COLOR_W-1:0] BLUE,
    output logic [COORD_W-1:0] SCROLL
);

    localparam int RGB_W = 3 * COLOR_W;
    // Product is widened when the RGB slice reaches beyond its top bit.
    localparam int PW = (2 * COORD_W > RGB_W + 2) ? 2 * COORD_W : RGB_W + 2;
    localparam logic [COORD_W-1:0] X_LO = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0] X_HI = COORD_W'(H_ACTIVE - BORDER);
    localparam logic [COORD_W-1:0] Y_LO = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0] Y_HI = COORD_W'(V_ACTIVE - BORDER);

    logic [1:0]           mode_q;
    logic [2:0]           csel_q;
    logic [COORD_W-1:0]   scroll_s;

`ifdef VGA_SCROLL_EN
    vga_frame_ticker #(
        .COORD_W   (COORD_W),
        .FRAME_DIV (FRAME_DIV)
    ) u_ticker (
        .clk_i    (CLK_100MHz),
        .rst_ni   (RST_N),
        .vblank_i (VBlank),
        .scroll_o (scroll_s)
    );
`else
    assign scroll_s = {COORD_W{1'b0}};
`endif

    assign SCROLL = scroll_s;

    // Selection latch: only updated during vertical blanking.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            mode_q <= 2'b00;
            csel_q <= 3'b000;
        end else if (VBlank) begin
            mode_q <= SWITCH[4:3];
            csel_q <= SWITCH[2:0];
        end
    end

    // Stage 1 next-state.
    logic [COORD_W-1:0]   xs_s;
    logic [2*COORD_W-1:0] p_s;
    logic [PW-1:0]        p_ext_s;
    logic                 blank_d, border_d;
    logic [2:0]           bar_d;
    logic [RGB_W-1:0]     prod_d;

    // Stage 1 arithmetic: scrolled X, border test on raw X, X*Y product.
    always_comb begin
        xs_s     = CurrentX + scroll_s;
        blank_d  = VBlank | HBlank;
        border_d = (CurrentX < X_LO) | (CurrentX > X_HI) |
                   (CurrentY < Y_LO) | (CurrentY > Y_HI);
        p_s      = {{COORD_W{1'b0}}, xs_s} * {{COORD_W{1'b0}}, CurrentY};
        p_ext_s  = PW'(p_s);
        prod_d   = RGB_W'(p_ext_s >> 2);
        bar_d    = 3'(xs_s >> BAR_SHIFT);
    end

    logic                 blank_q, border_q, ovl_valid_q;
    logic [2:0]           bar_q;
    logic [RGB_W-1:0]     prod_q;
    logic [RGB_W-1:0]     ovl_q;

    // Stage 1 registers; blank resets high so outputs stay dark until real data.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            blank_q     <= 1'b1;
            border_q    <= 1'b0;
            bar_q       <= 3'b000;
            prod_q      <= {RGB_W{1'b0}};
            ovl_q       <= {RGB_W{1'b0}};
            ovl_valid_q <= 1'b0;
        end else begin
            blank_q     <= blank_d;
            border_q    <= border_d;
            bar_q       <= bar_d;
            prod_q      <= prod_d;
            ovl_q       <= {OVL_RED, OVL_GREEN, OVL_BLUE};
            ovl_valid_q <= OVL_VALID;
        end
    end

    logic [RGB_W-1:0]      rgb_d, rgb_q;
    logic [3*MAX_CW-1:0]   fill_s, bars_s;

    // Stage 2 colour selection.
    always_comb begin
        rgb_d  = {RGB_W{1'b0}};
        fill_s = expand3(csel_q, COLOR_W);
        bars_s = expand3(bar_q, COLOR_W);
        if (blank_q) begin
            rgb_d = {RGB_W{1'b0}};
        end else begin
            case (mode_q)
                MODE_BORDER: begin
                    if (border_q) begin
                        rgb_d = {RGB_W{1'b1}};
                    end else if (csel_q == 3'b111) begin
                        rgb_d = {3{COLOR_W'(grey_level(COLOR_W))}};
                    end else begin
                        rgb_d = {COLOR_W'(fill_s >> (2 * MAX_CW)),
                                 COLOR_W'(fill_s >> MAX_CW),
                                 COLOR_W'(fill_s)};
                    end
                end
                MODE_PRODUCT: rgb_d = prod_q;
                MODE_BARS: begin
                    rgb_d = {COLOR_W'(bars_s >> (2 * MAX_CW)),
                             COLOR_W'(bars_s >> MAX_CW),
                             COLOR_W'(bars_s)};
                end
                MODE_OVERLAY: rgb_d = ovl_valid_q ? ovl_q : {RGB_W{1'b1}};
                default:      rgb_d = {RGB_W{1'b0}};
            endcase
        end
    end

    // Stage 2 output register.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            rgb_q <= {RGB_W{1'b0}};
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign RED   = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign GREEN = rgb_q[2*COLOR_W-1:COLOR_W];
    assign BLUE  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_pattern_client.sv
// Bench for vga_pattern_client (default parameters). A frame-level model
// predicts the colour of each pixel and the scroll offset from the tick count;
// a negedge process compares every cycle, and directed literals pin the model.
module tb_vga_pattern_client;

    logic        clk;
    logic        rst_n;
    logic [10:0] cx, cy;
    logic        vb, hb;
    logic [4:0]  sw;
    logic [3:0]  ovr, ovg, ovb;
    logic        ovv;
    logic [3:0]  red, green, blue;
    logic [10:0] scroll;

    int checks = 0;
    int errors = 0;
    bit run_chk = 1'b0;

    vga_pattern_client dut (
        .CLK_100MHz (clk),
        .RST_N      (rst_n),
        .CurrentX   (cx),
        .CurrentY   (cy),
        .VBlank     (vb),
        .HBlank     (hb),
        .SWITCH     (sw),
        .OVL_RED    (ovr),
        .OVL_GREEN  (ovg),
        .OVL_BLUE   (ovb),
        .OVL_VALID  (ovv),
        .RED        (red),
        .GREEN      (green),
        .BLUE       (blue),
        .SCROLL     (scroll)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    logic [11:0] m_s1, m_out;
    logic [1:0]  mode_m;
    logic [2:0]  csel_m;
    int          ticks_m;
    bit          vbp_m;

    function automatic logic [10:0] scroll_of(input int t);
`ifdef VGA_SCROLL_EN
        return 11'((t / 4) % 2048);
`else
        return 11'(t * 0);
`endif
    endfunction

    function automatic logic [11:0] exp3(input logic [2:0] s);
        return {(s[2] ? 4'hF : 4'h0), (s[1] ? 4'hF : 4'h0), (s[0] ? 4'hF : 4'h0)};
    endfunction

    function automatic logic [11:0] model_rgb(input int x, input int y,
                                              input bit vbl, input bit hbl,
                                              input logic [1:0] md, input logic [2:0] cs,
                                              input int sc, input logic [11:0] ovl,
                                              input bit ovvalid);
        int xs;
        bit border;
        xs     = (x + sc) % 2048;
        border = (x < 100) || (x > 700) || (y < 100) || (y > 500);
        if (vbl || hbl) return 12'h000;
        case (md)
            2'd0: begin
                if (border) return 12'hFFF;
                if (cs == 3'd7) return 12'h777;
                return exp3(cs);
            end
            2'd1: return 12'((xs * y) >> 2);
            2'd2: return exp3(3'((xs >> 5) & 7));
            2'd3: return ovvalid ? ovl : 12'hFFF;
            default: return 12'h000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1    <= 12'h000;
            m_out   <= 12'h000;
            mode_m  <= 2'd0;
            csel_m  <= 3'd0;
            ticks_m <= 0;
            vbp_m   <= 1'b1;
        end else begin
            m_out <= m_s1;
            m_s1  <= model_rgb(int'(cx), int'(cy), vb, hb, mode_m, csel_m,
                               int'(scroll_of(ticks_m)), {ovr, ovg, ovb}, ovv);
            if (vb) begin
                mode_m <= sw[4:3];
                csel_m <= sw[2:0];
            end
            if (vb && !vbp_m) ticks_m <= ticks_m + 1;
            vbp_m <= vb;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("pipe_rgb", {20'd0, red, green, blue}, {20'd0, m_out});
            chk("pipe_scroll", {21'd0, scroll}, {21'd0, scroll_of(ticks_m)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int x, input int y, input bit v, input bit h);
        cx = 11'(x);
        cy = 11'(y);
        vb = v;
        hb = h;
        @(negedge clk);
    endtask

    task automatic vpulse(input logic [4:0] s);
        sw = s;
        step(0, 0, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b1);
    endtask

    task automatic pump(input int target, input logic [4:0] s);
        for (int i = 0; i < 9000; i++) begin
            if (ticks_m >= target) break;
            vpulse(s);
        end
        if (ticks_m != target) begin
            checks++;
            errors++;
            $display("FAIL pump: reached %0d ticks, wanted %0d", ticks_m, target);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        cx = 11'd400; cy = 11'd300; vb = 1'b0; hb = 1'b0; sw = 5'd0;
        ovr = 4'h0; ovg = 4'h0; ovb = 4'h0; ovv = 1'b0;
        #1 rst_n = 1'b0;
        run_chk = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rgb", {20'd0, red, green, blue}, 32'h000);
        chk("reset_scroll", {21'd0, scroll}, 32'd0);
        rst_n = 1'b1;

        // Latency: border pixel shows only on the second edge.
        step(50, 300, 1'b0, 1'b0);
        chk("lat1_dark", {20'd0, red, green, blue}, 32'h000);
        step(400, 300, 1'b0, 1'b0);
        chk("first_valid", {20'd0, red, green, blue}, 32'hFFF);

        // Mode 00, CSEL=001.
        vpulse(5'b00_001);
        step(50, 300, 1'b0, 1'b0);
        step(400, 300, 1'b0, 1'b0);
        chk("m0_border", {20'd0, red, green, blue}, 32'hFFF);
        step(400, 300, 1'b0, 1'b0);
        chk("m0_fill", {20'd0, red, green, blue}, 32'h00F);
        sw = 5'b00_111;
        step(400, 300, 1'b0, 1'b0);
        step(400, 300, 1'b0, 1'b0);
        chk("m0_midframe_hold", {20'd0, red, green, blue}, 32'h00F);
        vpulse(5'b00_111);
        step(400, 300, 1'b0, 1'b0);
        step(400, 300, 1'b0, 1'b0);
        chk("m0_grey", {20'd0, red, green, blue}, 32'h777);

        // Mode 01, scroll still 0.
        vpulse(5'b01_000);
        step(3, 5, 1'b0, 1'b0);
        step(800, 600, 1'b0, 1'b1);
        chk("m1_product", {20'd0, red, green, blue}, 32'h003);
        step(400, 300, 1'b0, 1'b0);
        chk("m1_hblank", {20'd0, red, green, blue}, 32'h000);

        // Mode 11 overlay.
        vpulse(5'b11_000);
        ovr = 4'hA; ovg = 4'h5; ovb = 4'hC; ovv = 1'b1;
        step(400, 300, 1'b0, 1'b0);
        ovv = 1'b0;
        step(400, 300, 1'b0, 1'b0);
        chk("m3_overlay", {20'd0, red, green, blue}, 32'hA5C);
        step(400, 300, 1'b0, 1'b0);
        chk("m3_no_overlay", {20'd0, red, green, blue}, 32'hFFF);

        // Eight frame ticks since reset.
        repeat (4) vpulse(5'b11_000);
`ifdef VGA_SCROLL_EN
        chk("scroll_8_ticks", {21'd0, scroll}, 32'd2);
        pump(128, 5'b10_000);
        step(0, 300, 1'b0, 1'b0);
        step(0, 300, 1'b0, 1'b0);
        chk("m2_bar_scroll32", {20'd0, red, green, blue}, 32'h00F);
        pump(8188, 5'b10_000);
        chk("scroll_max", {21'd0, scroll}, 32'd2047);
        repeat (4) vpulse(5'b10_000);
        chk("scroll_wrap", {21'd0, scroll}, 32'd0);
`else
        chk("scroll_8_ticks", {21'd0, scroll}, 32'd0);
        for (int f = 0; f < 20; f++) begin
            vpulse(5'b10_000);
            step(40, 300, 1'b0, 1'b0);
            step(40, 300, 1'b0, 1'b0);
            chk("m2_static_bar", {20'd0, red, green, blue}, 32'h00F);
            chk("scroll_static", {21'd0, scroll}, 32'd0);
        end
`endif

        run_chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pattern_client.md
Name: vga_pattern_client

Overview:
- Parametrised, pipelined successor of the VGA colour client.
- Computes the RGB colour for pixel (CurrentX, CurrentY) from a frame-latched mode/colour selection.
- Adds a frame-rate scroll counter and a registered 2-stage output pipeline.
- Sits between the VGA timing generator and the DAC/pin outputs; the timing generator must compensate for the fixed 2-cycle latency.

Parameters:
- COLOR_W, 4, bits per colour channel.
- COORD_W, 11, width of the X/Y coordinates.
- H_ACTIVE, 800, visible pixels per line.
- V_ACTIVE, 600, visible lines per frame.
- BORDER, 100, border width in pixels.
- BAR_SHIFT, 5, log2 of colour-bar width (32 px).
- FRAME_DIV, 4, frames per scroll step (must be ≥1).

Ports:
- CLK_100MHz  in  1  pixel/system clock.
- RST_N  in  1  asynchronous, active-low reset.
- CurrentX  in  COORD_W  current pixel column.
- CurrentY  in  COORD_W  current pixel row.
- VBlank  in  1  vertical blanking.
- HBlank  in  1  horizontal blanking.
- SWITCH  in  5  [2:0] colour select, [4:3] mode select.
- OVL_RED, OVL_GREEN, OVL_BLUE  in  COLOR_W each  overlay pixel colour.
- OVL_VALID  in  1  overlay pixel present.
- RED, GREEN, BLUE  out  COLOR_W each  registered colour outputs.
- SCROLL  out  COORD_W  current scroll offset (status/debug).

Behaviour:
- Reset (RST_N low, asynchronous): RED/GREEN/BLUE=0, SCROLL=0, mode=0, colour select=0, pipeline registers=0, blank flags=1.
- Selection latch: MODE<=SWITCH[4:3] and CSEL<=SWITCH[2:0] on every clock with VBlank=1; held otherwise. HBlank alone does not update the selection, so changes land only at frame boundaries.
- Frame ticker:
  - VBlank registered once; the rising edge (VBlank & !VBlank_d) is the frame tick.
  - Divider counts 0..FRAME_DIV-1 on ticks.
  - On a tick at FRAME_DIV-1, the divider clears and SCROLL increments, wrapping modulo 2^COORD_W (all-ones -> 0).
- Pipeline stage 1 registers:
  - blank = VBlank|HBlank
  - XS = (CurrentX+SCROLL) mod 2^COORD_W
  - Y
  - border flag = X<BORDER | X>H_ACTIVE-BORDER | Y<BORDER | Y>V_ACTIVE-BORDER (uses unscrolled X)
  - product P = XS*Y, full 2*COORD_W bits
  - the overlay inputs and OVL_VALID
- Pipeline stage 2 registers RGB; latency is exactly 2 clocks from inputs to outputs.
  - If the stage-2 blank flag is set: RGB=0.
  - MODE 00: border ? all-ones : fill. Fill = expand(CSEL), where each CSEL bit replicates to a full channel (bit2=R, bit1=G, bit0=B). CSEL=111 instead gives mid-grey 2^(COLOR_W-1)-1 per channel.
  - MODE 01: {R,G,B}=P[3*COLOR_W+1:2] (zero-extended if P is narrower).
  - MODE 10: colour bars, expand(XS[BAR_SHIFT+2:BAR_SHIFT]).
  - MODE 11: OVL_VALID ? overlay : all-ones.
- Boundary cases:
  - SWITCH changes during active video have no effect until the next VBlank.
  - A reset mid-line blanks outputs immediately.
  - Coordinates beyond the active area follow the same arithmetic; the blank flag gates output.
  - A tick coinciding with reset release is ignored (VBlank_d resets to 1).

Optional Feature:
- Macro: VGA_SCROLL_EN.
- Defined: frame ticker and SCROLL behave as above.
- Undefined: ticker logic is removed, SCROLL is tied to 0, XS=CurrentX, and modes 01/10 are static.

Decomposition:
- Package vga_pkg:
  - mode constants MODE_BORDER=2'b00, MODE_PRODUCT=2'b01, MODE_BARS=2'b10, MODE_OVERLAY=2'b11
  - colour-expand function expand3(sel, COLOR_W)
  - grey constant
- Sub-module vga_frame_ticker (VBlank edge detect, FRAME_DIV divider, SCROLL counter), instantiated only under VGA_SCROLL_EN.

Test Plan:
- Reset: hold RST_N=0 with active pixel inputs -> RGB=0, SCROLL=0. Release -> first valid RGB appears 2 clocks after the first active pixel.
- MODE 00, CSEL=001 latched in VBlank: X=50,Y=300 -> 0xFFF; X=400,Y=300 -> 0x00F two clocks later. Set CSEL=111 mid-frame -> no change until next VBlank, then 0x777.
- MODE 01, SCROLL=0: X=3,Y=5 -> P=15 -> {R,G,B}=0x003. X=800,Y=600 with HBlank=1 -> 0x000.
- Scroll: FRAME_DIV=4, 8 VBlank rising edges -> SCROLL=2. Preload to 2047 plus one step -> 0. MODE 10, X=0 with SCROLL=32 -> bar 1 -> 0x00F.
- MODE 11: OVL_VALID=1 with overlay A/5/C -> 0xA5C. OVL_VALID=0 -> 0xFFF.
- Macro off: 20 frames -> SCROLL stays 0, mode 10 output unchanged frame to frame.
